// File: rtl/inv_pkg.sv
// Shared widths, FSM encoding and matrix packing helpers for the 2x2 inverse scheduler.
package inv_pkg;

    localparam int ELEM_W = 4;
    localparam int ADJ_W  = 5;
    localparam int DET_W  = 8;
    localparam int MAT_W  = 4 * ELEM_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ELEM_W-1:0] d11;
        logic [ELEM_W-1:0] d12;
        logic [ELEM_W-1:0] d21;
        logic [ELEM_W-1:0] d22;
    } mat_t;

    function automatic mat_t unpack_mat(input logic [MAT_W-1:0] raw);
        mat_t m;
        m.d11 = raw[15:12];
        m.d12 = raw[11:8];
        m.d21 = raw[7:4];
        m.d22 = raw[3:0];
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] pack_mat(input mat_t m);
        return {m.d11, m.d12, m.d21, m.d22};
    endfunction

    function automatic logic signed [ADJ_W-1:0] sext_adj(input logic [ELEM_W-1:0] e);
        return {e[ELEM_W-1], e};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        // A grant is only issued against a live request, so it is always an accept.
        last_grant_d = last_grant_q;
        if (gnt != 2'b00) begin
            last_grant_d = gnt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/inv_sched.sv
// Arbitrates two requesters and computes adjugate and determinant of a 2x2 signed
// matrix using a single time-shared multiplier.
module inv_sched
    import inv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [MAT_W-1:0]       req0_mat,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [MAT_W-1:0]       req1_mat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_id,
    output logic [4*ADJ_W-1:0]     out_adj,
    output logic [DET_W-1:0]       out_det,
    output logic                   out_nonsing
);

    function automatic logic signed [DET_W-1:0] sext_det(input logic [ELEM_W-1:0] e);
        return {{(DET_W-ELEM_W){e[ELEM_W-1]}}, e};
    endfunction

    state_t                   state_q, state_d;
    mat_t                     mat_q, mat_d;
    logic                     id_q, id_d;
    logic signed [DET_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_id_q, out_id_d;
    logic [4*ADJ_W-1:0]       out_adj_q, out_adj_d;
    logic [DET_W-1:0]         out_det_q, out_det_d;
    logic                     out_nonsing_q, out_nonsing_d;

    logic [1:0]               gnt;
    logic                     arb_en;
    logic signed [DET_W-1:0]  mul_a, mul_b, prod, det;

    // Readies are held low while reset is asserted so no accept can precede the first edge.
    assign arb_en = (state_q == S_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req0_ready  = gnt[0];
    assign req1_ready  = gnt[1];
    assign out_valid   = out_valid_q;
    assign out_id      = out_id_q;
    assign out_adj     = out_adj_q;
    assign out_det     = out_det_q;
    assign out_nonsing = out_nonsing_q;

    // The one multiplier sees d11*d22 in MUL1 and d12*d21 in MUL2.
    always_comb begin
        mul_a = (state_q == S_MUL1) ? sext_det(mat_q.d11) : sext_det(mat_q.d12);
        mul_b = (state_q == S_MUL1) ? sext_det(mat_q.d22) : sext_det(mat_q.d21);
        prod  = mul_a * mul_b;
        det   = acc_q - prod;
    end

    always_comb begin
        state_d       = state_q;
        mat_d         = mat_q;
        id_d          = id_q;
        acc_d         = acc_q;
        out_valid_d   = out_valid_q;
        out_id_d      = out_id_q;
        out_adj_d     = out_adj_q;
        out_det_d     = out_det_q;
        out_nonsing_d = out_nonsing_q;
        case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    mat_d   = unpack_mat(gnt[1] ? req1_mat : req0_mat);
                    id_d    = gnt[1];
                    state_d = S_MUL1;
                end
            end
            S_MUL1: begin
                acc_d   = prod;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                acc_d         = det;
                out_valid_d   = 1'b1;
                out_id_d      = id_q;
                out_det_d     = det;
                out_nonsing_d = (det != '0);
                out_adj_d     = {sext_adj(mat_q.d22), -sext_adj(mat_q.d12),
                                 -sext_adj(mat_q.d21), sext_adj(mat_q.d11)};
                state_d       = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_id_q      <= 1'b0;
            out_adj_q     <= '0;
            out_det_q     <= '0;
            out_nonsing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            out_valid_q   <= out_valid_d;
            out_id_q      <= out_id_d;
            out_adj_q     <= out_adj_d;
            out_det_q     <= out_det_d;
            out_nonsing_q <= out_nonsing_d;
        end
    end

    // Captured operands need no reset: they are only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        mat_q <= mat_d;
        id_q  <= id_d;
    end

endmodule

// File: tb/tb_inv_sched.sv
// Directed and randomized checks of inv_sched against an arithmetic reference model.
`timescale 1ns/1ps
module tb_inv_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_mat;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_mat;
  logic        out_valid, out_ready, out_id, out_nonsing;
  logic [19:0] out_adj;
  logic [7:0]  out_det;

  int ncmp  = 0;
  int nfail = 0;
  int lastg = 1;

  inv_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_mat    (req0_mat),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_mat    (req1_mat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_adj     (out_adj),
    .out_det     (out_det),
    .out_nonsing (out_nonsing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nfail++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    ncmp++;
    if (out_valid !== 1'b0) fail({tag, "_valid"}, out_valid, 1'b0);
    ncmp++;
    if ({req1_ready, req0_ready} !== 2'b00) fail({tag, "_rdy"}, {req1_ready, req0_ready}, 2'b00);
    ncmp++;
    if (out_adj !== 20'h0) fail({tag, "_adj"}, out_adj, 20'h0);
    ncmp++;
    if (out_det !== 8'h0) fail({tag, "_det"}, out_det, 8'h0);
    ncmp++;
    if (out_nonsing !== 1'b0) fail({tag, "_nons"}, out_nonsing, 1'b0);
    ncmp++;
    if (out_id !== 1'b0) fail({tag, "_id"}, out_id, 1'b0);
  endtask

  task automatic serve(input int hold);
    int win, cyc, d11, d12, d21, d22, det;
    logic [15:0] m;
    logic [4:0]  a11, a12, a21, a22;
    logic [19:0] exp_adj;
    logic [7:0]  exp_det;
    logic [1:0]  exp_gnt;
    logic        exp_id;
    logic        exp_ns;

    if (req0_valid && req1_valid) win = (lastg == 1) ? 0 : 1;
    else win = req0_valid ? 0 : 1;
    m = (win == 1) ? req1_mat : req0_mat;
    d11 = $signed(m[15:12]);
    d12 = $signed(m[11:8]);
    d21 = $signed(m[7:4]);
    d22 = $signed(m[3:0]);
    det = d11 * d22 - d12 * d21;
    a22 = 5'(d22);
    a12 = 5'(-d12);
    a21 = 5'(-d21);
    a11 = 5'(d11);
    exp_adj = {a22, a12, a21, a11};
    exp_det = 8'(det);
    exp_gnt = (win == 1) ? 2'b10 : 2'b01;
    exp_id  = (win == 1);
    exp_ns  = (det != 0);
    out_ready = (hold == 0);

    @(negedge clk);
    cyc = 0;
    while (!(req0_ready || req1_ready) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    ncmp++;
    if (cyc !== 0) fail("accept_wait", cyc, 0);
    if (cyc >= 20) return;
    ncmp++;
    if ({req1_ready, req0_ready} !== exp_gnt) fail("grant", {req1_ready, req0_ready}, exp_gnt);

    @(posedge clk);
    #1;
    if (win == 1) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    lastg = win;

    repeat (2) begin
      @(negedge clk);
      ncmp++;
      if (out_valid !== 1'b0) fail("busy_valid", out_valid, 1'b0);
      ncmp++;
      if ({req1_ready, req0_ready} !== 2'b00) fail("busy_ready", {req1_ready, req0_ready}, 2'b00);
    end

    @(negedge clk);
    ncmp++;
    if (out_valid !== 1'b1) fail("valid", out_valid, 1'b1);
    ncmp++;
    if (out_adj !== exp_adj) fail("adj", out_adj, exp_adj);
    ncmp++;
    if (out_det !== exp_det) fail("det", out_det, exp_det);
    ncmp++;
    if (out_nonsing !== exp_ns) fail("nonsing", out_nonsing, exp_ns);
    ncmp++;
    if (out_id !== exp_id) fail("id", out_id, exp_id);

    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (k == hold - 1) out_ready = 1'b1;
      @(negedge clk);
      ncmp++;
      if (out_valid !== 1'b1) fail("hold_valid", out_valid, 1'b1);
      ncmp++;
      if (out_adj !== exp_adj) fail("hold_adj", out_adj, exp_adj);
      ncmp++;
      if (out_det !== exp_det) fail("hold_det", out_det, exp_det);
      ncmp++;
      if (out_id !== exp_id) fail("hold_id", out_id, exp_id);
      ncmp++;
      if ({req1_ready, req0_ready} !== 2'b00) fail("hold_ready", {req1_ready, req0_ready}, 2'b00);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b1;
    req0_mat   = 16'h1234;
    req1_valid = 1'b0;
    req1_mat   = 16'h0;
    out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic inverse, then a singular matrix.
    serve(0);
    req1_valid = 1'b1;
    req1_mat   = 16'h2412;
    serve(0);

    // Extreme values: negation of -8 and determinant limits.
    req0_valid = 1'b1;
    req0_mat   = 16'h8887;
    serve(0);
    req1_valid = 1'b1;
    req1_mat   = 16'h8878;
    serve(0);

    // Both requesters held valid: grants must alternate.
    req0_valid = 1'b1;
    req0_mat   = 16'h7F31;
    req1_valid = 1'b1;
    req1_mat   = 16'hC5A2;
    for (int i = 0; i < 4; i++) begin
      serve(0);
      if (!req0_valid) begin req0_valid = 1'b1; req0_mat = 16'($urandom); end
      if (!req1_valid) begin req1_valid = 1'b1; req1_mat = 16'($urandom); end
    end

    // Back-pressure for 5 cycles; the pending requester must be accepted right after.
    serve(5);
    serve(0);

    // Reset while the matrix sits in MUL2.
    req0_valid = 1'b1;
    req0_mat   = 16'h1234;
    req1_valid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (req0_ready !== 1'b1) fail("mid_grant", req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst   = 1'b0;
    lastg = 1;
    repeat (6) begin
      @(negedge clk);
      ncmp++;
      if (out_valid !== 1'b0) fail("no_ghost", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req0_mat   = 16'h3159;
    req1_valid = 1'b1;
    req1_mat   = 16'hE6B4;
    serve(0);
    serve(0);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1;
        req0_mat   = 16'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1;
        req1_mat   = 16'($urandom);
      end
      if (!req0_valid && !req1_valid) begin
        req0_valid = 1'b1;
        req0_mat   = 16'($urandom);
      end
      serve(int'($urandom_range(0, 2)));
    end
    while (req0_valid || req1_valid) serve(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
